// File: rtl/coin_dispenser.sv
// coin_dispenser: greedy change-payout engine driving three coin hopper lines
// (1.0 / 0.5 / 0.1 yuan). Amounts are in 0.1-yuan units.
// Optional closed-loop hopper acknowledge with jam detection is enabled by
// defining the macro COIN_DISP_ACK_EN; the default build is open-loop.
`timescale 1ns/1ps
module coin_dispenser #(
  parameter int PULSE_CYC   = 10,
  parameter int GAP_CYC     = 10,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [6:0] amount,
  input  logic       hopper_ack,
  output logic       coin10,
  output logic       coin5,
  output logic       coin1,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] remaining,
  output logic [6:0] paid
);

  // One shared down-timer serves PULSE, GAP and WAIT_ACK, so it is sized for
  // the longest of the three.
  localparam int PG_MAX  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_MAX = (PG_MAX > ACK_TIMEOUT) ? PG_MAX : ACK_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

`ifdef COIN_DISP_ACK_EN
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEL      = 3'd1,
    PULSE    = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4,
    WAIT_ACK = 3'd5,
    ERR      = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;
`endif

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       denom;
  logic [6:0]       sel_denom;
  logic             pulse_end;
  logic             gap_end;
  logic             confirm;
  logic             timed;
`ifdef COIN_DISP_ACK_EN
  logic             ack_expire;
`else
  // hopper_ack has no function in the open-loop build.
  logic             unused_ack;
  assign unused_ack = hopper_ack;
`endif

  // Greedy denomination choice: largest coin not exceeding what is left.
  function automatic logic [6:0] pick_denom(input logic [6:0] rem);
    if (rem >= 7'd10)
      pick_denom = 7'd10;
    else if (rem >= 7'd5)
      pick_denom = 7'd5;
    else
      pick_denom = 7'd1;
  endfunction

  assign sel_denom = pick_denom(remaining);
  assign pulse_end = (state == PULSE) && (cnt == PULSE_LAST);
  assign gap_end   = (state == GAP) && (cnt == GAP_LAST);

`ifdef COIN_DISP_ACK_EN
  assign confirm    = (state == WAIT_ACK) && hopper_ack;
  assign ack_expire = (state == WAIT_ACK) && !hopper_ack && (cnt == ACK_LAST);
  assign timed      = (state == PULSE) || (state == GAP) || (state == WAIT_ACK);
`else
  assign confirm    = pulse_end;
  assign timed      = (state == PULSE) || (state == GAP);
`endif

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Next-state decode plus the state-derived status outputs.
  always_comb begin
    nxt  = state;
    busy = 1'b1;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          nxt = SEL;
      end
      SEL: begin
        if (remaining == 7'd0)
          nxt = DONE;
        else
          nxt = PULSE;
      end
      PULSE: begin
        if (pulse_end) begin
`ifdef COIN_DISP_ACK_EN
          nxt = WAIT_ACK;
`else
          nxt = GAP;
`endif
        end
      end
`ifdef COIN_DISP_ACK_EN
      WAIT_ACK: begin
        if (confirm)
          nxt = GAP;
        else if (ack_expire)
          nxt = ERR;
      end
      ERR: begin
        nxt = DONE;
      end
`endif
      GAP: begin
        if (gap_end)
          nxt = SEL;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Phase timer: restarts on every state change, runs only in timed states.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt <= '0;
    else if (nxt != state)
      cnt <= '0;
    else if (timed)
      cnt <= cnt + 1'b1;
  end

  // Registered coin drives: raised on the SEL exit edge, dropped at PULSE end,
  // so only the selected line can ever be high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coin10 <= 1'b0;
      coin5  <= 1'b0;
      coin1  <= 1'b0;
      denom  <= 7'd0;
    end else if ((state == SEL) && (remaining != 7'd0)) begin
      coin10 <= (sel_denom == 7'd10);
      coin5  <= (sel_denom == 7'd5);
      coin1  <= (sel_denom == 7'd1);
      denom  <= sel_denom;
    end else if (pulse_end) begin
      coin10 <= 1'b0;
      coin5  <= 1'b0;
      coin1  <= 1'b0;
    end
  end

  // Payout ledger: remaining+paid stays equal to the accepted amount, and a
  // coin moves from remaining to paid only when it is confirmed delivered.
  // The greedy choice guarantees denom <= remaining, so neither side wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      remaining <= 7'd0;
      paid      <= 7'd0;
    end else if ((state == IDLE) && start) begin
      remaining <= amount;
      paid      <= 7'd0;
    end else if (confirm) begin
      remaining <= remaining - denom;
      paid      <= paid + denom;
    end
  end

  // Jam flag: sticky until the next accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      err <= 1'b0;
    else if ((state == IDLE) && start)
      err <= 1'b0;
`ifdef COIN_DISP_ACK_EN
    else if (ack_expire)
      err <= 1'b1;
`endif
  end

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed testbench for coin_dispenser with PULSE_CYC=2, GAP_CYC=3,
// ACK_TIMEOUT=8. Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_coin_dispenser;

  localparam int P = 2;
  localparam int G = 3;
  localparam int K = 1 + P + G;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [6:0] amount;
  logic       hopper_ack;
  logic       coin10;
  logic       coin5;
  logic       coin1;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] remaining;
  logic [6:0] paid;

  int errors = 0;
  int checks = 0;

  coin_dispenser #(
    .PULSE_CYC  (P),
    .GAP_CYC    (G),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .amount    (amount),
    .hopper_ack(hopper_ack),
    .coin10    (coin10),
    .coin5     (coin5),
    .coin1     (coin1),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining),
    .paid      (paid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {coin10, coin5, coin1, busy, done, err, remaining, paid};
  endfunction

  // Open-loop payout of amt checked every cycle against the greedy schedule.
  // Optionally re-asserts start (with re_amt) during cycle re_cyc.
  task automatic run_payout(input int amt, input int re_cyc, input logic [6:0] re_amt);
    int dn[20];
    int n;
    int r;
    int done_cyc;
    n = 0;
    r = amt;
    while (r > 0) begin
      dn[n] = (r >= 10) ? 10 : (r >= 5) ? 5 : 1;
      r -= dn[n];
      n++;
    end
    done_cyc = 2 + n * K;
    amount = 7'(amt);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      int i;
      int off;
      int sum;
      logic [2:0] coin_e;
      logic [19:0] exp;
      i   = (c - 1) / K;
      off = (c - 1) % K;
      coin_e = 3'b000;
      if (i < n && off >= 1 && off <= P)
        coin_e = {dn[i] == 10, dn[i] == 5, dn[i] == 1};
      sum = 0;
      for (int j = 0; j < n; j++)
        if (2 + j * K + P <= c)
          sum += dn[j];
      exp = {coin_e, (c <= done_cyc), (c == done_cyc), 1'b0, 7'(amt - sum), 7'(sum)};
      check($sformatf("amt%0d_cyc%0d", amt, c), {12'd0, outs()}, {12'd0, exp});
      if (c == re_cyc) begin
        start  = 1'b1;
        amount = re_amt;
      end else begin
        start  = 1'b0;
        amount = 7'(amt);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    amount     = 7'd0;
    hopper_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {12'd0, outs()}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_after_release", {12'd0, outs()}, 32'd0);

`ifdef COIN_DISP_ACK_EN
    // amount=6: coin5 acked at latency 3, coin1 never acked -> jam.
    amount = 7'd6;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      if (c == 2)  check("ack_coin5_high", {31'd0, coin5}, 32'd1);
      if (c == 4)  check("ack_wait_coin_low", {29'd0, coin10, coin5, coin1}, 32'd0);
      if (c == 6)  check("ack_unconfirmed", {18'd0, remaining, paid}, {18'd0, 7'd6, 7'd0});
      if (c == 7)  check("ack_confirmed", {18'd0, remaining, paid}, {18'd0, 7'd1, 7'd5});
      if (c == 11) check("ack_coin1_high", {31'd0, coin1}, 32'd1);
      if (c == 13) check("ack_coin1_low", {31'd0, coin1}, 32'd0);
      if (c == 20) check("jam_not_yet", {29'd0, busy, done, err}, {29'd0, 3'b100});
      if (c == 21) check("jam_err_state", {15'd0, busy, done, err, remaining, paid},
                         {15'd0, 3'b101, 7'd1, 7'd5});
      if (c == 22) check("jam_done", {29'd0, busy, done, err}, {29'd0, 3'b111});
      if (c == 23) check("jam_idle_sticky", {29'd0, busy, done, err}, {29'd0, 3'b001});
      hopper_ack = (c == 6);
      @(negedge clk);
    end
    hopper_ack = 1'b0;
`else
    // Mixed denominations.
    run_payout(37, 0, 7'd0);
    // Zero amount: no coins, done at cycle 2.
    run_payout(0, 0, 7'd0);
    // start while busy is ignored.
    run_payout(15, 10, 7'd99);

    // Asynchronous reset during the second coin10 pulse of amount=25.
    amount = 7'd25;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(negedge clk);
    check("rst_pre_coin10", {31'd0, coin10}, 32'd1);
    #2 rstn = 1'b0;
    #1 check("rst_async_outputs", {12'd0, outs()}, 32'd0);
    @(negedge clk);
    check("rst_held_outputs", {12'd0, outs()}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    run_payout(25, 0, 7'd0);

    // Maximum amount, with hopper_ack toggling to show it is ignored.
    hopper_ack = 1'b1;
    run_payout(127, 0, 7'd0);
    hopper_ack = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
